// File: rtl/imem_responder.sv
// Instruction RAM responder for the fetch request protocol, with program-load port and flush.
// Latency: LATENCY cycles from accepted strobe to response. No backpressure: every strobe is accepted.
// Flush drops in-flight responses; a strobe in the flush cycle is still answered.
module imem_responder #(
    parameter int    ADDR_W    = 12,
    parameter int    LATENCY   = 2,
    parameter string INIT_FILE = ""
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] mem_req_addr,
    input  logic        mem_req_stb,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_data,
    output logic        mem_req_err,
    input  logic        i_flush,
    input  logic        ld_we,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    output logic [31:0] req_count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       r_mem [DEPTH];
    logic              r_vld [LATENCY];
    logic              r_err [LATENCY];
    logic [31:0]       r_dat [LATENCY];

    logic [ADDR_W-1:0] w_rd_idx;
    logic [ADDR_W-1:0] w_ld_idx;
    logic              w_rd_fault;
    logic              w_ld_ok;
    logic              w_fwd;
    logic [31:0]       w_rd_dat;

    assign w_rd_idx   = mem_req_addr[ADDR_W+1:2];
    assign w_ld_idx   = ld_addr[ADDR_W+1:2];
    assign w_rd_fault = (mem_req_addr[1:0] != 2'b00) || ((mem_req_addr >> (ADDR_W + 2)) != 32'd0);
    assign w_ld_ok    = ld_we && (ld_addr[1:0] == 2'b00) && ((ld_addr >> (ADDR_W + 2)) == 32'd0);

    // Write-first: a same-cycle load to the requested word is forwarded into the response.
    assign w_fwd    = w_ld_ok && (w_ld_idx == w_rd_idx);
    assign w_rd_dat = w_rd_fault ? 32'd0 : (w_fwd ? ld_data : r_mem[w_rd_idx]);

    always_ff @(posedge i_clk) begin
        if (w_ld_ok) begin
            r_mem[w_ld_idx] <= ld_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < LATENCY; k++) begin
                r_vld[k] <= 1'b0;
                r_err[k] <= 1'b0;
                r_dat[k] <= 32'd0;
            end
            req_count <= 32'd0;
        end else begin
            r_vld[0] <= mem_req_stb;
            r_err[0] <= mem_req_stb & w_rd_fault;
            r_dat[0] <= mem_req_stb ? w_rd_dat : 32'd0;
            // Stage 0 holds the request of this edge, so flush only kills older stages.
            for (int k = 1; k < LATENCY; k++) begin
                r_vld[k] <= r_vld[k-1] & ~i_flush;
                r_err[k] <= r_err[k-1];
                r_dat[k] <= r_dat[k-1];
            end
            if (mem_req_stb) begin
                req_count <= req_count + 32'd1;
            end
        end
    end

    assign mem_req_valid = r_vld[LATENCY-1];
    assign mem_req_err   = r_vld[LATENCY-1] & r_err[LATENCY-1];
    assign mem_req_data  = r_vld[LATENCY-1] ? r_dat[LATENCY-1] : 32'd0;

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: randomized fetch/load/flush traffic against a word-level memory model.
module tb_imem_responder;
    localparam int L     = 2;
    localparam int AW    = 12;
    localparam int NWORD = 128;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [31:0] mem_req_addr = '0;
    logic        mem_req_stb = 1'b0;
    logic        mem_req_valid;
    logic [31:0] mem_req_data;
    logic        mem_req_err;
    logic        i_flush = 1'b0;
    logic        ld_we = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic [31:0] req_count;

    always #5 clk = ~clk;

    imem_responder #(.ADDR_W(AW), .LATENCY(L), .INIT_FILE("")) dut (
        .i_clk(clk), .i_reset(i_reset),
        .mem_req_addr(mem_req_addr), .mem_req_stb(mem_req_stb),
        .mem_req_valid(mem_req_valid), .mem_req_data(mem_req_data), .mem_req_err(mem_req_err),
        .i_flush(i_flush), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .req_count(req_count)
    );

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mm[int];
    logic [31:0] model_cnt = '0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    bit          in_reset = 1'b1;
    bit          done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
        return (a % 4 == 0) && ((a / 4) < (1 << AW));
    endfunction

    // Drive one cycle of inputs, then apply the spec rules for that edge to the model.
    task automatic step(input bit stb, input logic [31:0] a, input bit fl,
                        input bit we, input logic [31:0] la, input logic [31:0] ld);
        int   en;
        exp_t x;
        mem_req_stb = stb; mem_req_addr = a; i_flush = fl;
        ld_we = we; ld_addr = la; ld_data = ld;
        @(posedge clk);
        #1;
        en = cyc;
        if (fl)
            while (exp_q.size() > 0 && exp_q[$].due >= en) void'(exp_q.pop_back());
        if (we && addr_ok(la)) mm[int'(la / 4)] = ld;
        if (stb) begin
            model_cnt = model_cnt + 32'd1;
            x.due = en + L - 1;
            if (addr_ok(a)) begin
                x.d = mm[int'(a / 4)];
                x.e = 1'b0;
            end else begin
                x.d = 32'd0;
                x.e = 1'b1;
            end
            exp_q.push_back(x);
        end
        mem_req_stb = 1'b0; i_flush = 1'b0; ld_we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 32'd0, 0, 0, 32'd0, 32'd0);
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] w;
        w = 32'($urandom_range(0, NWORD - 1));
        if ($urandom_range(0, 99) < 85) return w * 4;
        if ($urandom_range(0, 1) == 1) return w * 4 + 32'($urandom_range(1, 3));
        return 32'h0000_4000 + w * 4 + (32'($urandom_range(0, 7)) << 20);
    endfunction

    task automatic random_traffic(input int n);
        for (int i = 0; i < n; i++)
            step($urandom_range(0, 9) < 7, rnd_addr(), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 4) == 0, rnd_addr(), $urandom());
    endtask

    always @(negedge clk) begin
        if (!in_reset && !done) begin
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                checks++;
                failures++;
                $display("FAIL missed_resp: got none expected %h due cycle %0d", exp_q[0].d, exp_q[0].due);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_valid", {31'd0, mem_req_valid}, 32'd1);
                check("resp_data", mem_req_data, e.d);
                check("resp_err", {31'd0, mem_req_err}, {31'd0, e.e});
            end else begin
                check("idle_valid", {31'd0, mem_req_valid}, 32'd0);
                check("idle_data", mem_req_data, 32'd0);
                check("idle_err", {31'd0, mem_req_err}, 32'd0);
            end
            check("req_count", req_count, model_cnt);
        end
    end

    initial begin
        #2;
        check("rst_valid", {31'd0, mem_req_valid}, 32'd0);
        check("rst_data", mem_req_data, 32'd0);
        check("rst_err", {31'd0, mem_req_err}, 32'd0);
        check("rst_count", req_count, 32'd0);
        #10;
        i_reset = 1'b0;
        in_reset = 1'b0;

        for (int w = 0; w < NWORD; w++) step(0, 32'd0, 0, 1, 32'(w * 4), $urandom());

        // Load then fetch a known word
        step(0, 32'd0, 0, 1, 32'h40, 32'hDEAD_BEEF);
        step(1, 32'h40, 0, 0, 32'd0, 32'd0);
        idle(3);
        // Back-to-back stream
        step(1, 32'h0, 0, 0, 32'd0, 32'd0);
        step(1, 32'h4, 0, 0, 32'd0, 32'd0);
        step(1, 32'h8, 0, 0, 32'd0, 32'd0);
        step(1, 32'hC, 0, 0, 32'd0, 32'd0);
        idle(3);
        check("cnt_after_stream", req_count, 32'd5);
        // Misaligned and out-of-range fetches
        step(1, 32'h42, 0, 0, 32'd0, 32'd0);
        step(1, 32'h0001_0000, 0, 0, 32'd0, 32'd0);
        idle(3);
        // Flush with a redirect fetch in the flush cycle
        step(1, 32'h0, 0, 0, 32'd0, 32'd0);
        step(1, 32'h4, 0, 0, 32'd0, 32'd0);
        step(1, 32'h100, 1, 0, 32'd0, 32'd0);
        idle(3);
        check("cnt_after_flush", req_count, 32'd10);
        // Same-cycle load and fetch of one word; then ignored bad loads
        step(1, 32'h20, 0, 1, 32'h20, 32'h1234_5678);
        step(0, 32'd0, 0, 1, 32'h0000_4020, 32'hBAD0_0001);
        step(0, 32'd0, 0, 1, 32'h0000_0021, 32'hBAD0_0002);
        step(1, 32'h20, 0, 0, 32'd0, 32'd0);
        idle(3);

        random_traffic(600);

        // Asynchronous reset with requests in flight
        step(1, 32'h8, 0, 0, 32'd0, 32'd0);
        step(1, 32'hC, 0, 0, 32'd0, 32'd0);
        #2;
        i_reset = 1'b1;
        in_reset = 1'b1;
        #1;
        check("async_rst_valid", {31'd0, mem_req_valid}, 32'd0);
        check("async_rst_data", mem_req_data, 32'd0);
        check("async_rst_err", {31'd0, mem_req_err}, 32'd0);
        check("async_rst_count", req_count, 32'd0);
        exp_q.delete();
        model_cnt = '0;
        repeat (2) @(posedge clk);
        #3;
        i_reset = 1'b0;
        in_reset = 1'b0;
        idle(4);

        random_traffic(300);
        idle(L + 3);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
